// File: rtl/rx_uart.sv
// UART receiver: 8N1 deframer, 16x oversampled on the shared baud tick.
// Rx is synchronized, the start bit is confirmed mid-bit, then data bits are
// sampled LSB first at mid-bit. The word, the frame-error flag and a
// one-clock done pulse are presented on registered outputs.
module rx_uart #(
    parameter int NB_DATA = 8,   // data bits per frame
    parameter int SB_TICK = 16,  // s_tick count spent in the stop state
    parameter int NB_SYNC = 2    // rx synchronizer depth (minimum 2)
) (
    input  logic               clock,
    input  logic               reset,         // asynchronous, active-low
    input  logic               rx,
    input  logic               s_tick,
    output logic [NB_DATA-1:0] dout,
    output logic               rx_done_tick,
    output logic               frame_error,
    output logic               busy
);

    // A synchronizer shorter than two stages is not a synchronizer.
    localparam int SYNC_W = (NB_SYNC < 2) ? 2 : NB_SYNC;
    localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [3:0]        S_MID    = 4'd7;
    localparam logic [3:0]        S_LAST   = 4'd15;
    localparam logic [3:0]        S_STOP   = 4'(SB_TICK - 1);
    localparam logic [NB_CNT-1:0] N_LAST   = NB_CNT'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizer
    // ---------------------------------------------------------------------
    logic [SYNC_W-1:0] sync_q, sync_d;
    logic              rx_s;

    // Next synchronizer contents: shift rx in at the bottom.
    always_comb begin
        sync_d = {sync_q[SYNC_W-2:0], rx};
    end

    // Synchronizer flops; they reset to the idle-line level so reset does not
    // look like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[SYNC_W-1];

    // ---------------------------------------------------------------------
    // Deframing FSM
    // ---------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          s_cnt_q, s_cnt_d;
    logic [NB_CNT-1:0]   n_cnt_q, n_cnt_d;
    logic [NB_DATA-1:0]  shift_q, shift_d;
    logic [NB_DATA-1:0]  dout_q, dout_d;
    logic                done_q, done_d;
    logic                fe_q, fe_d;

    // Next-state logic: everything advances only on s_tick, except leaving
    // IDLE, which reacts to the falling edge on the very next clock.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        fe_d    = fe_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_cnt_q == S_MID) begin
                        if (!rx_s) begin
                            // Still low at mid start bit: a real frame.
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            // Line went back high: a glitch, drop it silently.
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        // LSB arrives first, so shift in from the top.
                        shift_d = NB_DATA'({rx_s, shift_q} >> 1);
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == S_STOP) begin
                        // Mid stop bit: deliver the word even if the stop bit
                        // is bad, and go back to hunting for the next start.
                        state_d = IDLE;
                        dout_d  = shift_q;
                        fe_d    = ~rx_s;
                        done_d  = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_error  = fe_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Testbench for rx_uart: a bench serializer drives 8N1 frames, a scoreboard
// queue holds the expected word / frame-error / start time for every frame,
// and an independent monitor checks each rx_done_tick against it.
module tb_rx_uart;

    localparam int  CLK_HALF = 5;
    localparam int  BIT_CLKS = 64;  // s_tick every 4 clocks, 16 ticks per bit
    localparam int  LAT_MIN  = 600; // 9.5 bit times = 608 clocks, +/- tick phase
    localparam int  LAT_MAX  = 620;

    logic       clock;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_error;
    logic       busy;

    rx_uart #(
        .NB_DATA(8),
        .SB_TICK(16),
        .NB_SYNC(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .s_tick      (s_tick),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .frame_error (frame_error),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       fe;
        longint     t0;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_dout = 8'h00;
    logic       busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Clock.
    initial begin
        clock = 1'b0;
        forever #CLK_HALF clock = ~clock;
    end

    // Baud tick: one clock high out of every four, driven on the falling edge.
    initial begin : tick_gen
        int ph;
        ph = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clock);
            ph = (ph + 1) % 4;
            s_tick = (ph == 0);
        end
    end

    // Monitor: every done pulse must match the oldest outstanding frame.
    initial begin : monitor
        exp_t   e;
        longint lat;
        forever begin
            @(negedge clock);
            if (busy === 1'b1) busy_seen = 1'b1;
            if (rx_done_tick === 1'b1) begin
                check("pulse_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    model_dout = e.data;
                    check("dout", dout, e.data);
                    check("frame_error", frame_error, e.fe);
                    check("busy_low_at_done", busy, 0);
                    lat = ($time - e.t0) / (2 * CLK_HALF);
                    checks++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL done_latency: got %0d clocks expected %0d..%0d",
                                 lat, LAT_MIN, LAT_MAX);
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Serialize one 8N1 frame. A bad stop bit is driven low for the first
    // three quarters of the bit (so the receiver samples 0 mid-bit) and then
    // released; the receiver's immediate restart on that low level must be
    // rejected as a glitch, which is why bad frames need at least one idle bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap_bits);
        exp_t e;
        e.data = d;
        e.fe   = ~stop_ok;
        e.t0   = $time;
        exp_q.push_back(e);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            rx = 1'b0;
            wait_clks(BIT_CLKS * 3 / 4);
            rx = 1'b1;
            wait_clks(BIT_CLKS / 4);
        end
        rx = 1'b1;
        wait_clks(gap_bits * BIT_CLKS);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("drain_before_timeout", exp_q.size(), 0);
    endtask

    initial begin : stim
        logic [7:0] b77;
        logic [7:0] rd;
        logic       ok;
        rx    = 1'b1;
        reset = 1'b0;

        // Reset held: outputs stay at reset values whatever rx and s_tick do.
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            rx = 1'($urandom_range(0, 1));
            #1;
            check("rst_dout", dout, 8'h00);
            check("rst_done", rx_done_tick, 0);
            check("rst_fe", frame_error, 0);
            check("rst_busy", busy, 0);
        end
        @(negedge clock);
        rx = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // Basic frame.
        send_frame(8'hA5, 1'b1, 1);
        wait_drain();

        // Glitch: low for 4 ticks, then high; no frame, dout unchanged.
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_idle", busy, 0);
        check("glitch_dout_held", dout, model_dout);

        // Framing error, then recovery with a good frame.
        send_frame(8'h3C, 1'b0, 1);
        send_frame(8'h00, 1'b1, 1);
        wait_drain();

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h81, 1'b1, 1);
        wait_drain();

        // Reset in the middle of data bit 3 of 0x77: no pulse, outputs cleared.
        b77 = 8'h77;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = b77[i];
            wait_clks(BIT_CLKS);
        end
        rx = b77[3];
        wait_clks(BIT_CLKS / 2);
        check("midrst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_done", rx_done_tick, 0);
        check("midrst_fe", frame_error, 0);
        check("midrst_busy", busy, 0);
        model_dout = 8'h00;
        wait_clks(10);
        rx = 1'b1;
        reset = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("post_rst_dout", dout, model_dout);
        send_frame(8'h5A, 1'b1, 1);
        wait_drain();

        // Randomized frames, occasional bad stop bits, random idle gaps.
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(rd, ok, ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
        end
        wait_drain();
        wait_clks(4 * BIT_CLKS);
        check("no_outstanding_frames", exp_q.size(), 0);
        check("final_busy_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
